// File: rtl/switch_io_pkg.sv
// Shared register offsets, CTRL bit positions and sizing helper for the switch input peripheral.
package switch_io_pkg;

  localparam logic [3:0] OFF_STATUS = 4'h0;
  localparam logic [3:0] OFF_EVENTS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_RSVD   = 4'hC;

  localparam int IRQ_EN_BIT = 0;

  // Counter only has to reach cycles-1, so $clog2(cycles) bits suffice; keep at least one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch: 2-flop synchroniser, stability counter and debounced level flop.
// stable follows the pin DEBOUNCE_CYCLES+2 edges after a change; rise pulses in the cycle before stable goes 0->1.
module sw_debounce
  import switch_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic stable,
  output logic rise
);

  localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle where the synchronised level agrees with stable restarts the qualification window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sw_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = stable_d & ~stable_q;

endmodule

// File: rtl/switch_input_ctrl.sv
// Memory-mapped debounced switch block: STATUS/EVENTS(W1C)/CTRL window on the data bus, level irq.
// rdata is combinational from addr; events and irq update on the edge after the triggering cycle.
module switch_input_ctrl
  import switch_io_pkg::*;
#(
  parameter int          N_SW            = 5,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0400
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_raw,
  input  logic [31:0]     addr,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [N_SW-1:0] sw_stable,
  output logic            irq
);

  logic [N_SW-1:0] rise;
  logic [N_SW-1:0] events_q;
  logic [N_SW-1:0] events_d;
  logic [N_SW-1:0] clr_mask;
  logic            irq_en_q;
  logic            irq_en_d;
  logic            irq_q;
  logic            irq_d;
  logic            hit;
  logic [3:0]      off;
  logic            wr_events;
  logic            wr_ctrl;

  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .sw_raw(sw_raw[g]),
      .stable(sw_stable[g]),
      .rise  (rise[g])
    );
  end

  if (N_SW < 32) begin : g_wdata_pad
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:N_SW];
  end

  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign off       = addr[3:0];
  assign wr_events = hit && we && (off == OFF_EVENTS);
  assign wr_ctrl   = hit && we && (off == OFF_CTRL);
  assign clr_mask  = {N_SW{wr_events}} & wdata[N_SW-1:0];

  // Set is OR-ed in after the clear so a new edge is never lost to a racing W1C.
  always_comb begin
    events_d = (events_q & ~clr_mask) | rise;
    irq_en_d = wr_ctrl ? wdata[IRQ_EN_BIT] : irq_en_q;
    irq_d    = irq_en_q & (|events_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      events_q <= '0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      events_q <= events_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: rdata[N_SW-1:0]   = sw_stable;
        OFF_EVENTS: rdata[N_SW-1:0]   = events_q;
        OFF_CTRL:   rdata[IRQ_EN_BIT] = irq_en_q;
        default:    rdata = '0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule
